// File: rtl/alu_nibble_sequencer_if.sv
// rtl/alu_nibble_sequencer_if.sv - operand, slice and result signals of the nibble sequencer
interface alu_nibble_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // upstream operand handshake
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_s;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_c_in;

  // 4-bit arithmetic slice connection
  logic [3:0]   au_s;
  logic [3:0]   au_a;
  logic [3:0]   au_b;
  logic         au_c_in;
  logic [3:0]   au_f;
  logic         au_c_out;

  // downstream result handshake
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_f;
  logic         out_c_out;
  logic         out_zero;

  // sequencer side
  modport slave (
    input  in_valid, in_s, in_a, in_b, in_c_in,
    output in_ready,
    output au_s, au_a, au_b, au_c_in,
    input  au_f, au_c_out,
    output out_valid, out_f, out_c_out, out_zero,
    input  out_ready
  );

  // operand source, slice and result consumer side
  modport master (
    output in_valid, in_s, in_a, in_b, in_c_in,
    input  in_ready,
    input  au_s, au_a, au_b, au_c_in,
    output au_f, au_c_out,
    input  out_valid, out_f, out_c_out, out_zero,
    output out_ready
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - wide arithmetic via one 4-bit slice, one nibble per cycle
module alu_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_nibble_sequencer_if.slave  bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [3:0]       s_q;
  logic [W-1:0]     result;
  logic [W-1:0]     out_f_q;
  logic             out_c_out_q;
  logic             out_zero_q;

  // bit offset of the nibble currently in flight
  logic [IDX_W+1:0] base;
  logic [W-1:0]     result_nxt;
  logic             running;

  assign base    = {idx, 2'b00};
  assign running = (state == RUN);

  // result word with the current slice output merged into its nibble
  always_comb begin
    result_nxt = result;
    result_nxt[base +: 4] = bus.au_f;
  end

  // slice drive: operand nibbles only while running, select always visible
  assign bus.au_s    = s_q;
  assign bus.au_a    = running ? a_q[base +: 4] : 4'h0;
  assign bus.au_b    = running ? b_q[base +: 4] : 4'h0;
  assign bus.au_c_in = running ? carry : 1'b0;

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_f     = out_f_q;
  assign bus.out_c_out = out_c_out_q;
  assign bus.out_zero  = out_zero_q;

  // sequencer FSM: capture operands, walk nibbles LSB first, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= 4'h0;
      result      <= '0;
      out_f_q     <= '0;
      out_c_out_q <= 1'b0;
      out_zero_q  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
            s_q   <= bus.in_s;
            carry <= bus.in_c_in;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result <= result_nxt;
          carry  <= bus.au_c_out;
          if (idx == IDX_LAST) begin
            out_f_q     <= result_nxt;
            out_c_out_q <= bus.au_c_out;
            out_zero_q  <= ~|result_nxt;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb/tb_alu_nibble_sequencer.sv - directed self-checking bench for alu_nibble_sequencer
module tb_alu_nibble_sequencer;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_nibble_sequencer_if #(.NIBBLES(4)) bus ();

  alu_nibble_sequencer #(.NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slice model: 1001 a+b+c, 0000 a+c, 0110 a+~b+c
  logic [4:0] sum;
  always_comb begin
    sum = 5'd0;
    case (bus.au_s)
      4'b1001: sum = {1'b0, bus.au_a} + {1'b0, bus.au_b} + {4'b0, bus.au_c_in};
      4'b0000: sum = {1'b0, bus.au_a} + {4'b0, bus.au_c_in};
      4'b0110: sum = {1'b0, bus.au_a} + {1'b0, ~bus.au_b} + {4'b0, bus.au_c_in};
      default: sum = 5'd0;
    endcase
  end
  assign bus.au_f     = sum[3:0];
  assign bus.au_c_out = sum[4];

  logic [3:0] seq_a [4];
  logic       seq_c [4];
  logic [3:0] seq_s [4];
  logic       ready_at_offer;
  logic       early_valid;

  // offer one operand set, record slice drive over the RUN cycles, stop in DONE
  task automatic run_op(input logic [3:0] s, input logic [15:0] a,
                        input logic [15:0] b, input logic c);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_s     = s;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_c_in  = c;
    ready_at_offer = bus.in_ready;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    early_valid  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seq_a[i] = bus.au_a;
      seq_c[i] = bus.au_c_in;
      seq_s[i] = bus.au_s;
      if (bus.out_valid) early_valid = 1'b1;
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    total++;
    if (bus.out_f !== 16'h0000 || bus.out_c_out !== 1'b0 || bus.out_zero !== 1'b1) begin
      bad++;
      $display("FAIL reset_result: f=%h c=%b z=%b want 0000 0 1", bus.out_f, bus.out_c_out, bus.out_zero);
    end
    total++;
    if (bus.au_a !== 4'h0 || bus.au_b !== 4'h0 || bus.au_c_in !== 1'b0 || bus.au_s !== 4'h0) begin
      bad++;
      $display("FAIL reset_slice: a=%h b=%h c=%b s=%h want 0 0 0 0", bus.au_a, bus.au_b, bus.au_c_in, bus.au_s);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add_small();
    run_op(4'b1001, 16'h00FF, 16'h0001, 1'b0);
    total++;
    if (ready_at_offer !== 1'b1 || early_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_timing: ready=%b early_valid=%b want 1 0", ready_at_offer, early_valid);
    end
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL add_latency: out_valid=%b want 1", bus.out_valid);
    end
    total++;
    if (bus.out_f !== 16'h0100 || bus.out_c_out !== 1'b0 || bus.out_zero !== 1'b0) begin
      bad++;
      $display("FAIL add_result: f=%h c=%b z=%b want 0100 0 0", bus.out_f, bus.out_c_out, bus.out_zero);
    end
    total++;
    if (seq_s[0] !== 4'b1001 || seq_s[3] !== 4'b1001) begin
      bad++;
      $display("FAIL add_sel: s0=%b s3=%b want 1001", seq_s[0], seq_s[3]);
    end
    finish_op();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL add_release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_carry_chain();
    logic exp_c [4];
    exp_c[0] = 1'b0; exp_c[1] = 1'b1; exp_c[2] = 1'b1; exp_c[3] = 1'b1;
    run_op(4'b1001, 16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seq_c[i] !== exp_c[i]) begin
        bad++;
        $display("FAIL carry_seq[%0d]: au_c_in=%b want %b", i, seq_c[i], exp_c[i]);
      end
    end
    total++;
    if (bus.out_f !== 16'h0000 || bus.out_c_out !== 1'b1 || bus.out_zero !== 1'b1) begin
      bad++;
      $display("FAIL carry_result: f=%h c=%b z=%b want 0000 1 1", bus.out_f, bus.out_c_out, bus.out_zero);
    end
    finish_op();
  endtask

  task automatic test_pass_a();
    logic [3:0] exp_a [4];
    exp_a[0] = 4'h4; exp_a[1] = 4'h3; exp_a[2] = 4'h2; exp_a[3] = 4'h1;
    run_op(4'b0000, 16'h1234, 16'hFFFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seq_a[i] !== exp_a[i] || seq_s[i] !== 4'h0) begin
        bad++;
        $display("FAIL pass_seq[%0d]: au_a=%h au_s=%h want %h 0", i, seq_a[i], seq_s[i], exp_a[i]);
      end
    end
    total++;
    if (bus.out_f !== 16'h1235 || bus.out_c_out !== 1'b0) begin
      bad++;
      $display("FAIL pass_result: f=%h c=%b want 1235 0", bus.out_f, bus.out_c_out);
    end
    finish_op();
  endtask

  task automatic test_hold();
    run_op(4'b0110, 16'h0005, 16'h0007, 1'b1);
    total++;
    if (bus.out_f !== 16'hFFFE || bus.out_c_out !== 1'b0 || bus.out_zero !== 1'b0) begin
      bad++;
      $display("FAIL sub_result: f=%h c=%b z=%b want fffe 0 0", bus.out_f, bus.out_c_out, bus.out_zero);
    end
    bus.in_valid = 1'b1;
    bus.in_s     = 4'b1001;
    bus.in_a     = 16'h1111;
    bus.in_b     = 16'h1111;
    bus.in_c_in  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_f !== 16'hFFFE ||
          bus.out_c_out !== 1'b0 || bus.out_zero !== 1'b0 || bus.au_a !== 4'h0) begin
        bad++;
        $display("FAIL hold[%0d]: v=%b rdy=%b f=%h c=%b z=%b au_a=%h want 1 0 fffe 0 0 0",
                 i, bus.out_valid, bus.in_ready, bus.out_f, bus.out_c_out, bus.out_zero, bus.au_a);
      end
    end
    bus.in_valid = 1'b0;
    finish_op();
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_f !== 16'hFFFE) begin
      bad++;
      $display("FAIL hold_after: out_valid=%b f=%h want 0 fffe", bus.out_valid, bus.out_f);
    end
  endtask

  task automatic test_back_to_back();
    int          n_acc;
    int          n_res;
    int          cyc;
    int          acc_cyc [2];
    logic [15:0] res_f [2];
    logic        res_c [2];
    logic        will_acc;
    n_acc = 0;
    n_res = 0;
    cyc   = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_s      = 4'b1001;
    bus.in_a      = 16'h1111;
    bus.in_b      = 16'h2222;
    bus.in_c_in   = 1'b0;
    for (int k = 0; k < 40 && n_res < 2; k++) begin
      if (bus.out_valid) begin
        res_f[n_res] = bus.out_f;
        res_c[n_res] = bus.out_c_out;
        n_res++;
      end
      will_acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (will_acc && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          bus.in_a    = 16'h8000;
          bus.in_b    = 16'h8000;
          bus.in_c_in = 1'b1;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    total++;
    if (n_acc != 2 || n_res != 2) begin
      bad++;
      $display("FAIL b2b_count: accepts=%0d results=%0d want 2 2", n_acc, n_res);
    end
    if (n_acc == 2) begin
      total++;
      if (acc_cyc[1] - acc_cyc[0] != 6) begin
        bad++;
        $display("FAIL b2b_interval: %0d cycles want 6", acc_cyc[1] - acc_cyc[0]);
      end
    end
    if (n_res == 2) begin
      total++;
      if (res_f[0] !== 16'h3333 || res_c[0] !== 1'b0) begin
        bad++;
        $display("FAIL b2b_first: f=%h c=%b want 3333 0", res_f[0], res_c[0]);
      end
      total++;
      if (res_f[1] !== 16'h0001 || res_c[1] !== 1'b1) begin
        bad++;
        $display("FAIL b2b_second: f=%h c=%b want 0001 1", res_f[1], res_c[1]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic saw_valid;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_s     = 4'b1001;
    bus.in_a     = 16'hFFFF;
    bus.in_b     = 16'hFFFF;
    bus.in_c_in  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_f !== 16'h0000 ||
        bus.out_c_out !== 1'b0 || bus.out_zero !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_out: v=%b rdy=%b f=%h c=%b z=%b want 0 1 0000 0 1",
               bus.out_valid, bus.in_ready, bus.out_f, bus.out_c_out, bus.out_zero);
    end
    total++;
    if (bus.au_a !== 4'h0 || bus.au_b !== 4'h0 || bus.au_c_in !== 1'b0 || bus.au_s !== 4'h0) begin
      bad++;
      $display("FAIL rst_mid_slice: a=%h b=%h c=%b s=%h want 0 0 0 0", bus.au_a, bus.au_b, bus.au_c_in, bus.au_s);
    end
    #2;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) saw_valid = 1'b1;
    end
    total++;
    if (saw_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_valid: stray activity=%b want 0", saw_valid);
    end
    run_op(4'b1001, 16'h0001, 16'h0001, 1'b0);
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_f !== 16'h0002 || bus.out_c_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_recover: v=%b f=%h c=%b want 1 0002 0", bus.out_valid, bus.out_f, bus.out_c_out);
    end
    finish_op();
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    bus.in_valid  = 1'b0;
    bus.in_s      = 4'h0;
    bus.in_a      = 16'h0000;
    bus.in_b      = 16'h0000;
    bus.in_c_in   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b1;
    #2;
    rst_n = 1'b0;
    test_reset();
    test_add_small();
    test_carry_chain();
    test_pass_a();
    test_hold();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_nibble_sequencer.md
Name: alu_nibble_sequencer

Overview:
Multi-cycle wrapper that evaluates a wide arithmetic operation by driving one 4-bit arithmetic_unit slice, one nibble per cycle, least-significant nibble first. The slice's carry-out is registered and fed back as the next nibble's carry-in. The result nibbles are assembled into a wide result word. Upstream and downstream use valid/ready handshakes, so the block sits between the operand source and the result consumer, directly around the 4-bit slice.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream operand valid.
in_ready  output  1  block can accept an operand set.
in_s  input  4  function select, passed unchanged to the slice.
in_a  input  W  operand A.
in_b  input  W  operand B.
in_c_in  input  1  carry into nibble 0 (active-high).
au_s  output  4  to slice s.
au_a  output  4  to slice a.
au_b  output  4  to slice b.
au_c_in  output  1  to slice c_in.
au_f  input  4  from slice f (combinational, same cycle).
au_c_out  input  1  from slice c_out (combinational, same cycle).
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_f  output  W  assembled result.
out_c_out  output  1  carry out of the top nibble.
out_zero  output  1  high when out_f == 0.

Behaviour:
- Reset (async assert, sync-free release): state=IDLE; idx, carry, and the operand, select, and result registers all 0. Outputs: out_valid=0, out_f=0, out_c_out=0, out_zero=1, in_ready=1, and all au_* = 0.
- FSM states: IDLE, RUN, DONE. in_ready = (state==IDLE), driven combinationally from the state.
- IDLE: on in_valid && in_ready at an edge, capture in_a, in_b, in_s, and in_c_in into carry. Set idx=0 and go to RUN. Inputs are ignored in every other state.
- RUN (exactly NIBBLES cycles):
  - Drive au_a = A[4*idx+:4], au_b = B[4*idx+:4], au_c_in = carry, au_s = stored s.
  - At each edge: result[4*idx+:4] <= au_f; carry <= au_c_out.
  - If idx==NIBBLES-1, go to DONE; otherwise idx increments.
- DONE:
  - out_valid=1. out_f = result, out_c_out = carry, out_zero = ~|result.
  - All outputs hold stable while out_ready=0.
  - On out_ready, go to IDLE at that edge; out_valid drops.
- Outside RUN: au_a = au_b = 0, au_c_in = 0, au_s = stored s.
- out_f, out_c_out, and out_zero are registered. They keep their last values after a handshake until the next DONE.
- Latency: operand accepted at edge T, so out_valid rises after edge T+NIBBLES. Minimum issue interval is NIBBLES+2 cycles (one IDLE cycle is mandatory between operations).
- Carry polarity: no inversion anywhere; au_c_out of nibble i is the au_c_in of nibble i+1.
- NIBBLES=1: a single RUN cycle, and idx stays 0. The idx counter width is max(1, clog2(NIBBLES)).
- Reset mid-RUN or mid-DONE: the operation is abandoned, no out_valid is produced, and the block returns to the reset state immediately.
- in_valid held high in RUN/DONE: there is no acceptance and no overwrite of the captured operands.
- out_ready high while not in DONE: no effect.

Test Plan:
- NIBBLES=4, bench models the slice (s=1001 gives a+b+c_in; s=0000 gives a+c_in; s=0110 gives a+~b+c_in): s=1001, A=16'h00FF, B=16'h0001, c_in=0 -> out_f=16'h0100, out_c_out=0, out_zero=0, out_valid 4 cycles after acceptance.
- s=1001, A=16'hFFFF, B=16'h0001, c_in=0 -> out_f=16'h0000, out_c_out=1, out_zero=1; au_c_in sequence observed over the 4 RUN cycles is 0,1,1,1.
- s=0000, A=16'h1234, c_in=1 -> au_a sequence 4,3,2,1 over the RUN cycles, au_s=0 throughout, out_f=16'h1235.
- s=0110, A=16'h0005, B=16'h0007, c_in=1 -> out_f=16'hFFFE, out_c_out=0. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, and a new in_valid is ignored.
- Back-to-back: in_valid held high with out_ready=1 and two operand sets -> second accepted exactly NIBBLES+2 cycles after the first; both results correct.
- Reset pulse in the 2nd RUN cycle -> all outputs at reset values, with no out_valid. A subsequent operation (A=16'h0001, B=16'h0001, s=1001, c_in=0) gives out_f=16'h0002.
